regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Two-requester (ALU / LSU) register-file writeback arbiter.
//               Grants alternate under contention, accepted writes are
//               registered onto the register-file write port one cycle
//               later, and a per-register pending-write scoreboard tracks
//               destinations reserved by the issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  // requester 0 (ALU)
  input  logic                       req0_valid_i,
  output logic                       req0_ready_o,
  input  logic [ADDR_WIDTH-1:0]      req0_addr_i,
  input  logic [DATA_WIDTH-1:0]      req0_data_i,
  // requester 1 (LSU)
  input  logic                       req1_valid_i,
  output logic                       req1_ready_o,
  input  logic [ADDR_WIDTH-1:0]      req1_addr_i,
  input  logic [DATA_WIDTH-1:0]      req1_data_i,
  // issue-stage destination reservation
  input  logic                       claim_valid_i,
  input  logic [ADDR_WIDTH-1:0]      claim_addr_i,
  // pipeline flush
  input  logic                       flush_i,
  // register file write port
  output logic [ADDR_WIDTH-1:0]      waddr_o,
  output logic [DATA_WIDTH-1:0]      wdata_o,
  output logic                       we_o,
  // pending-write scoreboard, bit i = register i
  output logic [(2**ADDR_WIDTH)-1:0] pending_o
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                  prio_q,    prio_d;     // 1 = requester 1 favoured
  logic [ADDR_WIDTH-1:0] waddr_q,   waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
  logic                  we_q,      we_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;

  // ---------------------------------------------------------------------------
  // Arbitration wires
  // ---------------------------------------------------------------------------
  logic                  grant0;
  logic                  grant1;
  logic                  xfer0;
  logic                  xfer1;
  logic                  xfer;
  logic                  contended;
  logic [ADDR_WIDTH-1:0] xfer_addr;
  logic [DATA_WIDTH-1:0] xfer_data;

  // Grant selection: a lone requester always wins, a tie goes to prio;
  // reset and flush block every grant so nothing is accepted then.
  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    contended = req0_valid_i && req1_valid_i;
    if (!rst_i && !flush_i) begin
      if (contended) begin
        grant0 = !prio_q;
        grant1 =  prio_q;
      end else begin
        grant0 = req0_valid_i;
        grant1 = req1_valid_i;
      end
    end
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;

  assign xfer0     = req0_valid_i && grant0;
  assign xfer1     = req1_valid_i && grant1;
  assign xfer      = xfer0 || xfer1;
  assign xfer_addr = xfer1 ? req1_addr_i : req0_addr_i;
  assign xfer_data = xfer1 ? req1_data_i : req0_data_i;

  // Next-state: priority flip, writeback register, scoreboard update.
  always_comb begin
    prio_d    = prio_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    pending_d = pending_q;

    // The winner of a contended transfer yields to the loser next time.
    if (contended && xfer) begin
      prio_d = !prio_q;
    end

    // Capture the accepted write; writes to x0 are accepted but never
    // reach the register file.
    if (xfer) begin
      waddr_d = xfer_addr;
      wdata_d = xfer_data;
      we_d    = (xfer_addr != '0);
    end

    if (flush_i) begin
      pending_d = '0;
    end else begin
      // Clear first so a same-cycle claim of the same index wins.
      if (xfer) begin
        pending_d[xfer_addr] = 1'b0;
      end
      if (claim_valid_i) begin
        pending_d[claim_addr_i] = 1'b1;
      end
    end

    // Register x0 never has a pending write.
    pending_d[0] = 1'b0;
  end

  // State register with synchronous reset taking precedence over all else.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q    <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      pending_q <= '0;
    end else begin
      prio_q    <= prio_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      pending_q <= pending_d;
    end
  end

  assign waddr_o   = waddr_q;
  assign wdata_o   = wdata_q;
  assign we_o      = we_q;
  assign pending_o = pending_q;

endmodule

`default_nettype wire
